rail_pgood_monitor: RTL

- Receive-side companion to the power sequencer.
- Watches the rail enables the sequencer drives (3.3 V, 2.5 V, 1.2 V, reset request) and the regulators' raw power-good returns.
- Debounces power-good, checks ramp-up/ramp-down timing and enable ordering, and gates the system reset.
- Latches the first fault with a code so the controller can force the OFF sequence.

---
 rtl/rail_pgood_monitor.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rail_pgood_monitor.sv
// rail_pgood_monitor: debounces regulator power-good returns, times rail
// ramp-up/ramp-down against the sequencer enables, checks enable ordering,
// gates the downstream system reset and latches the first fault code.
module rail_pgood_monitor #(
  parameter logic [31:0] TMO_ON  = 32'd1000,
  parameter logic [31:0] TMO_OFF = 32'd1000,
  parameter logic [7:0]  DEB     = 8'd4,
  parameter int          CW      = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] en,
  input  logic       rst_req,
  input  logic [2:0] pg_raw,
  input  logic       fault_clr,
  output logic [2:0] pg,
  output logic       all_good,
  output logic       sys_rst_n,
  output logic       fault,
  output logic [3:0] fault_code,
  output logic [2:0] mon_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    GOOD  = 3'd2,
    DOWN  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [CW-1:0] TMO_ON_C  = CW'(TMO_ON);
  localparam logic [CW-1:0] TMO_OFF_C = CW'(TMO_OFF);

  // Timer increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Lowest-numbered active detection wins.
  function automatic logic [3:0] pick_code(input logic [11:1] hits);
    logic [3:0] code;
    code = 4'd0;
    for (int c = 11; c >= 1; c--) begin
      if (hits[c]) code = 4'(c);
    end
    return code;
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        sync_p0, sync_p1;
  logic [7:0]        deb_cnt [3];
  logic [2:0]        pg_p1;
  logic [2:0]        en_p1;
  logic [CW-1:0]     timer [3];
  logic [2:0]        armed_on, armed_off, reached;
  logic [2:0]        rise, fall, pg_fall;
  logic [11:1]       hits;
  logic [3:0]        det_code;

  assign rise      = en & ~en_p1;
  assign fall      = ~en & en_p1;
  assign pg_fall   = pg_p1 & ~pg;
  assign mon_state = state;

  // Two-flop synchroniser for the asynchronous power-good inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pg_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: pg follows the synced value only after DEB consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pg <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] != pg[i]) begin
          if (deb_cnt[i] + 8'd1 >= DEB) begin
            pg[i]      <= sync_p1[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // History of en and pg for edge detection, and per-rail "has been up" flag for brownout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_p1   <= '0;
      pg_p1   <= '0;
      reached <= '0;
    end else begin
      en_p1   <= en;
      pg_p1   <= pg;
      reached <= (reached | pg) & ~rise;
    end
  end

  // Per-rail ramp timers: restart on any enable edge, stop once pg reaches the expected level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_on  <= '0;
      armed_off <= '0;
      for (int i = 0; i < 3; i++) timer[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (rise[i]) begin
          timer[i]     <= '0;
          armed_on[i]  <= 1'b1;
          armed_off[i] <= 1'b0;
        end else if (fall[i]) begin
          timer[i]     <= '0;
          armed_on[i]  <= 1'b0;
          armed_off[i] <= 1'b1;
        end else begin
          if (armed_on[i] && pg[i]) armed_on[i] <= 1'b0;
          if (armed_off[i] && !pg[i]) armed_off[i] <= 1'b0;
          if (armed_on[i] || armed_off[i]) timer[i] <= sat_inc(timer[i]);
        end
      end
    end
  end

  // Raw fault detections, one bit per code, then priority-encoded.
  always_comb begin
    hits = '0;
    for (int i = 0; i < 3; i++) begin
      hits[1 + i] = armed_on[i]  && (timer[i] == TMO_ON_C)  && !pg[i];
      hits[4 + i] = armed_off[i] && (timer[i] == TMO_OFF_C) &&  pg[i];
      hits[7 + i] = pg_fall[i] && en[i] && reached[i];
    end
    hits[10] = rise[1] && !pg[0];
    hits[11] = rise[2] && !pg[1];
    det_code = pick_code(hits);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: any detection outside FAULT preempts the normal transitions.
  always_comb begin
    state_nxt = state;
    if (state != FAULT && det_code != 4'd0) begin
      state_nxt = FAULT;
    end else begin
      case (state)
        IDLE:  if (en != 3'b000) state_nxt = RAMP;
        RAMP:  begin
          if (en == 3'b111 && pg == 3'b111) state_nxt = GOOD;
          else if (en == 3'b000)            state_nxt = DOWN;
        end
        GOOD:  if (fall != 3'b000) state_nxt = DOWN;
        DOWN:  begin
          if (rise != 3'b000)                         state_nxt = RAMP;
          else if (en == 3'b000 && pg == 3'b000)      state_nxt = IDLE;
        end
        FAULT: if (fault_clr && en == 3'b000) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Registered status outputs track the state being entered, so sys_rst_n drops on the edge leaving GOOD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      all_good   <= 1'b0;
      sys_rst_n  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 4'd0;
    end else begin
      all_good  <= (state_nxt == GOOD);
      sys_rst_n <= (state_nxt == GOOD) && rst_req;
      fault     <= (state_nxt == FAULT);
      if (state != FAULT && det_code != 4'd0)
        fault_code <= det_code;
      else if (state == FAULT && state_nxt == IDLE)
        fault_code <= 4'd0;
    end
  end

endmodule
